// File: rtl/serial_borrow_subtractor.sv
// Digit-serial subtractor d = a - b - boin, LSB digit first, with start/busy/done handshake.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf_o.
module serial_borrow_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             boin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic             boout_o
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf_o
`endif
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one digit per edge, LSB digit first
    // DONE  | result valid, done pulse; a start here chains the next operation
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d, boout_q, boout_d;
    logic [DIGIT:0]   dig_diff;
    logic             accept, wr_res;

    assign dig_diff = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, borrow_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        boout_d  = boout_q;
        accept   = 1'b0;
        wr_res   = 1'b0;
        case (state_q)
            IDLE: accept = start_i;
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                // Result digits enter at the top and drift down to their final position.
                acc_d    = (acc_q >> DIGIT) | (WIDTH'(dig_diff[DIGIT-1:0]) << (WIDTH - DIGIT));
                borrow_d = dig_diff[DIGIT];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    wr_res  = 1'b1;
                    d_d     = acc_d;
                    boout_d = dig_diff[DIGIT];
                    state_d = DONE;
                end
            end
            DONE: begin
                accept  = start_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_d      = a_i;
            b_d      = b_i;
            borrow_d = boin_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            boout_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            boout_q  <= boout_d;
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic a_msb_q, b_msb_q, ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb_q <= a_i[WIDTH-1];
                b_msb_q <= b_i[WIDTH-1];
            end
            if (wr_res) begin
                ovf_q <= (a_msb_q != b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
            end
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign d_o     = d_q;
    assign boout_o = boout_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed self-checking bench: 8-bit/1-bit-digit instance plus exhaustive 4-bit/2-bit-digit instance.
module tb_serial_borrow_subtractor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, boin8, busy8, done8, boout8;
    logic [7:0] a8, b8, d8;
    logic       start4, boin4, busy4, done4, boout4;
    logic [3:0] a4, b4, d4;
`ifdef SUB_OVERFLOW_EN
    logic       ovf8, ovf4;
`endif

    int n_pass = 0;
    int n_total = 0;

    serial_borrow_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .boin_i(boin8),
        .busy_o(busy8), .done_o(done8), .d_o(d8), .boout_o(boout8)
`ifdef SUB_OVERFLOW_EN
        , .ovf_o(ovf8)
`endif
    );

    serial_borrow_subtractor #(.WIDTH(4), .DIGIT(2)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4), .boin_i(boin4),
        .busy_o(busy4), .done_o(done4), .d_o(d4), .boout_o(boout4)
`ifdef SUB_OVERFLOW_EN
        , .ovf_o(ovf4)
`endif
    );

    // Start one 8-bit operation from IDLE; operands are scrambled once accepted.
    // Returns in the DONE cycle (or after the bound expires).
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                           output int lat, output int busy_cnt);
        a8 = a; b8 = b; boin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~a; b8 = ~b; boin8 = ~bi;
        lat = 0; busy_cnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; boin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; boin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy8); else n_pass++;
        n_total++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done8); else n_pass++;
        n_total++; if (d8 !== 8'h00) $display("FAIL reset_d: got %h expected 00", d8); else n_pass++;
        n_total++; if (boout8 !== 1'b0) $display("FAIL reset_boout: got %b expected 0", boout8); else n_pass++;
        n_total++; if (busy4 !== 1'b0 || done4 !== 1'b0 || d4 !== 4'h0)
            $display("FAIL reset_w4: got busy=%b done=%b d=%h expected 0 0 0", busy4, done4, d4); else n_pass++;
`ifdef SUB_OVERFLOW_EN
        n_total++; if (ovf8 !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf8); else n_pass++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op8(8'h05, 8'h03, 1'b0, lat, bc);
        n_total++; if (lat !== 8) $display("FAIL basic_latency: got %0d expected 8", lat); else n_pass++;
        n_total++; if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d expected 8", bc); else n_pass++;
        n_total++; if (d8 !== 8'h02) $display("FAIL basic_d: got %h expected 02", d8); else n_pass++;
        n_total++; if (boout8 !== 1'b0) $display("FAIL basic_boout: got %b expected 0", boout8); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done8 !== 1'b0 || busy8 !== 1'b0)
            $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done8, busy8); else n_pass++;
        n_total++; if (d8 !== 8'h02) $display("FAIL basic_d_held: got %h expected 02", d8); else n_pass++;
    endtask

    task automatic test_borrow();
        int lat, bc;
        run_op8(8'h00, 8'h01, 1'b0, lat, bc);
        n_total++; if (d8 !== 8'hFF || boout8 !== 1'b1)
            $display("FAIL borrow_0m1: got d=%h bo=%b expected FF 1", d8, boout8); else n_pass++;
        @(posedge clk); #1;
        run_op8(8'h80, 8'h80, 1'b1, lat, bc);
        n_total++; if (d8 !== 8'hFF || boout8 !== 1'b1)
            $display("FAIL borrow_eq_boin: got d=%h bo=%b expected FF 1", d8, boout8); else n_pass++;
        @(posedge clk); #1;
        run_op8(8'h00, 8'hFF, 1'b1, lat, bc);
        n_total++; if (d8 !== 8'h00 || boout8 !== 1'b1)
            $display("FAIL borrow_0_ff_1: got d=%h bo=%b expected 00 1", d8, boout8); else n_pass++;
        @(posedge clk); #1;
        run_op8(8'hFF, 8'h00, 1'b0, lat, bc);
        n_total++; if (d8 !== 8'hFF || boout8 !== 1'b0)
            $display("FAIL borrow_ff_0: got d=%h bo=%b expected FF 0", d8, boout8); else n_pass++;
        @(posedge clk); #1;
        run_op8(8'hA5, 8'h3C, 1'b1, lat, bc);
        n_total++; if (d8 !== 8'h68 || boout8 !== 1'b0)
            $display("FAIL borrow_a5_3c_1: got d=%h bo=%b expected 68 0", d8, boout8); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        a8 = 8'h10; b8 = 8'h01; boin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; boin8 = 1'b1;
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_total++; if (lat !== 8) $display("FAIL b2b_first_latency: got %0d expected 8", lat); else n_pass++;
        n_total++; if (d8 !== 8'h0F || boout8 !== 1'b0)
            $display("FAIL b2b_first_result: got d=%h bo=%b expected 0F 0", d8, boout8); else n_pass++;
        @(posedge clk); #1;
        a8 = 8'h33; b8 = 8'h11; boin8 = 1'b0;
        n_total++; if (busy8 !== 1'b1) $display("FAIL b2b_rearm: got busy=%b expected 1", busy8); else n_pass++;
        lat = 1;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_total++; if (lat !== 9) $display("FAIL b2b_period: got %0d expected 9", lat); else n_pass++;
        n_total++; if (d8 !== 8'hFF || boout8 !== 1'b1)
            $display("FAIL b2b_second_result: got d=%h bo=%b expected FF 1", d8, boout8); else n_pass++;
        start8 = 1'b0;
        @(posedge clk); #1;
        n_total++; if (busy8 !== 1'b0 || done8 !== 1'b0)
            $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy8, done8); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int lat, bc;
        bit saw_done;
        a8 = 8'h05; b8 = 8'h03; boin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_total++; if (busy8 !== 1'b1) $display("FAIL rstmid_running: got busy=%b expected 1", busy8); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++; if (busy8 !== 1'b0 || done8 !== 1'b0)
            $display("FAIL rstmid_state: got busy=%b done=%b expected 0 0", busy8, done8); else n_pass++;
        n_total++; if (d8 !== 8'h00 || boout8 !== 1'b0)
            $display("FAIL rstmid_outputs: got d=%h bo=%b expected 00 0", d8, boout8); else n_pass++;
        saw_done = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done8) saw_done = 1'b1; end
        n_total++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done: got done pulse=%b expected 0", saw_done); else n_pass++;
        run_op8(8'h20, 8'h05, 1'b0, lat, bc);
        n_total++; if (lat !== 8 || d8 !== 8'h1B || boout8 !== 1'b0)
            $display("FAIL rstmid_restart: got lat=%0d d=%h bo=%b expected 8 1B 0", lat, d8, boout8); else n_pass++;
        @(posedge clk); #1;
        a8 = 8'h44; b8 = 8'h11; start8 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        n_total++; if (busy8 !== 1'b0 || d8 !== 8'h00)
            $display("FAIL rst_beats_start: got busy=%b d=%h expected 0 00", busy8, d8); else n_pass++;
        @(posedge clk); #1;
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_ovf();
        int lat, bc;
        run_op8(8'h80, 8'h01, 1'b0, lat, bc);
        n_total++; if (d8 !== 8'h7F || ovf8 !== 1'b1)
            $display("FAIL ovf_80_01: got d=%h ovf=%b expected 7F 1", d8, ovf8); else n_pass++;
        @(posedge clk); #1;
        run_op8(8'h7F, 8'hFF, 1'b0, lat, bc);
        n_total++; if (d8 !== 8'h80 || ovf8 !== 1'b1)
            $display("FAIL ovf_7f_ff: got d=%h ovf=%b expected 80 1", d8, ovf8); else n_pass++;
        @(posedge clk); #1;
        run_op8(8'h05, 8'h03, 1'b0, lat, bc);
        n_total++; if (d8 !== 8'h02 || ovf8 !== 1'b0)
            $display("FAIL ovf_05_03: got d=%h ovf=%b expected 02 0", d8, ovf8); else n_pass++;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_width4_exhaustive();
        int lat, expv;
        logic [3:0] exp_d;
        logic       exp_bo;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); boin4 = ic[0]; start4 = 1'b1;
                    @(posedge clk); #1;
                    start4 = 1'b0; a4 = ~a4; b4 = ~b4;
                    lat = 0;
                    while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
                    expv   = ia - ib - ic;
                    exp_d  = 4'(expv);
                    exp_bo = (expv < 0);
                    n_total++; if (d4 !== exp_d)
                        $display("FAIL w4_d a=%0d b=%0d bi=%0d: got %h expected %h", ia, ib, ic, d4, exp_d); else n_pass++;
                    n_total++; if (boout4 !== exp_bo)
                        $display("FAIL w4_boout a=%0d b=%0d bi=%0d: got %b expected %b", ia, ib, ic, boout4, exp_bo); else n_pass++;
                    n_total++; if (lat !== 2)
                        $display("FAIL w4_latency a=%0d b=%0d bi=%0d: got %0d expected 2", ia, ib, ic, lat); else n_pass++;
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_rst_mid();
`ifdef SUB_OVERFLOW_EN
        test_ovf();
`endif
        test_width4_exhaustive();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
